// File: rtl/cpu_pkg.sv
// Shared definitions for the decode / operand-fetch stage: ALU opcodes,
// instruction field positions, format bit and register address width.
package cpu_pkg;

    localparam int REG_AW = 2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SLL = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Format bit: 0 = R-type, 1 = I-type
    localparam int FMT_BIT   = 7;

    // R-type field positions
    localparam int R_OP_HI   = 6;
    localparam int R_OP_LO   = 5;
    localparam int R_RD_HI   = 4;
    localparam int R_RD_LO   = 3;
    localparam int R_RS_HI   = 2;
    localparam int R_RS_LO   = 1;

    // I-type field positions
    localparam int I_RD_HI   = 6;
    localparam int I_RD_LO   = 5;
    localparam int I_IMM_HI  = 4;
    localparam int I_IMM_LO  = 0;

    // Sign-extend a 5-bit immediate to the 8-bit datapath
    function automatic logic [7:0] sext_imm5(input logic [4:0] imm);
        return {{3{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// 4x8 register file, two combinational read ports, one write port.
// Optional macro OPERAND_FETCH_BYPASS_EN forwards the write data to a
// read port addressing the register being written in the same cycle.
module regfile_4x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr1,
    output logic [7:0]        rd_data1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [7:0]        rd_data2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data
);

    logic [7:0] mem_q [4];

    // Storage: cleared on reset, written on the write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    // Read ports with same-cycle writeback forwarding
    always_comb begin
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = mem_q[rd_addr1];
        end
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = mem_q[rd_addr2];
        end
    end
`else
    // Read ports return the stored value; a same-cycle write is not visible
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_data2 = mem_q[rd_addr2];
    end
`endif

endmodule

// File: rtl/operand_fetch.sv
// Decode and operand-fetch stage: decodes R/I instructions, reads the
// register file, blocks hazards with a per-register pending scoreboard and
// presents registered operands to execute. Optional macro:
// OPERAND_FETCH_BYPASS_EN (writeback-to-read forwarding).
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_instr,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] rs_data1,
    output logic [7:0] rs_data2,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic [1:0] rd_addr,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data
);

    logic              is_itype_s;
    logic [REG_AW-1:0] dec_rd_s;
    logic [REG_AW-1:0] dec_rs_s;
    logic [1:0]        dec_op_s;
    logic [7:0]        rf_rd1_s;
    logic [7:0]        rf_rd2_s;
    logic [NREG-1:0]   wb_clr_s;
    logic [NREG-1:0]   acc_set_s;
    logic [NREG-1:0]   pend_eff_s;
    logic              hazard_s;
    logic              accept_s;

    logic [NREG-1:0]   pending_q, pending_d;
    logic              out_valid_q;
    logic [7:0]        rs_data1_q;
    logic [7:0]        rs_data2_q;
    logic [1:0]        alu_op_q;
    logic              alu_src_q;
    logic [1:0]        rd_addr_q;

    regfile_4x8 u_rf (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (dec_rd_s),
        .rd_data1 (rf_rd1_s),
        .rd_addr2 (dec_rs_s),
        .rd_data2 (rf_rd2_s),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    // Field decode for both instruction formats
    always_comb begin
        is_itype_s = in_instr[FMT_BIT];
        dec_rs_s   = in_instr[R_RS_HI:R_RS_LO];
        if (is_itype_s) begin
            dec_rd_s = in_instr[I_RD_HI:I_RD_LO];
            dec_op_s = ALU_ADD;
        end else begin
            dec_rd_s = in_instr[R_RD_HI:R_RD_LO];
            dec_op_s = in_instr[R_OP_HI:R_OP_LO];
        end
    end

    // Hazard detection, handshake and next scoreboard state
    always_comb begin
        wb_clr_s = wb_en ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr) : {NREG{1'b0}};
`ifdef OPERAND_FETCH_BYPASS_EN
        pend_eff_s = pending_q & ~wb_clr_s;
`else
        pend_eff_s = pending_q;
`endif
        hazard_s  = pend_eff_s[dec_rd_s] || (!is_itype_s && pend_eff_s[dec_rs_s]);
        in_ready  = !hazard_s && (!out_valid_q || out_ready);
        accept_s  = in_valid && in_ready;
        acc_set_s = accept_s ? ({{(NREG-1){1'b0}}, 1'b1} << dec_rd_s) : {NREG{1'b0}};
        // An accept setting the same bit a writeback clears wins
        pending_d = (pending_q & ~wb_clr_s) | acc_set_s;
    end

    // Output register and scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= {NREG{1'b0}};
            out_valid_q <= 1'b0;
            rs_data1_q  <= 8'h00;
            rs_data2_q  <= 8'h00;
            alu_op_q    <= 2'b00;
            alu_src_q   <= 1'b0;
            rd_addr_q   <= 2'b00;
        end else begin
            pending_q <= pending_d;
            if (accept_s) begin
                out_valid_q <= 1'b1;
                rs_data1_q  <= rf_rd1_s;
                rs_data2_q  <= is_itype_s ? sext_imm5(in_instr[I_IMM_HI:I_IMM_LO]) : rf_rd2_s;
                alu_op_q    <= dec_op_s;
                alu_src_q   <= is_itype_s;
                rd_addr_q   <= dec_rd_s;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign rs_data1  = rs_data1_q;
    assign rs_data2  = rs_data2_q;
    assign alu_op    = alu_op_q;
    assign alu_src   = alu_src_q;
    assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch. Works with and without
// OPERAND_FETCH_BYPASS_EN defined.
module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_instr;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rs_data1;
    logic [7:0] rs_data2;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] rd_addr;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs_data1  (rs_data1),
        .rs_data2  (rs_data2),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .rd_addr   (rd_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_eq("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check_eq("rst_rs1",       rs_data1, 8'h00);
        check_eq("rst_rs2",       rs_data2, 8'h00);
        check_eq("rst_op",        {6'd0, alu_op}, 8'h00);
        check_eq("rst_src",       {7'd0, alu_src}, 8'h00);
        check_eq("rst_rd",        {6'd0, rd_addr}, 8'h00);
        check_eq("rst_in_ready",  {7'd0, in_ready}, 8'h01);

        // Load R1=5, R2=3, idle one cycle
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h05; tick();
        wb_addr = 2'd2; wb_data = 8'h03; tick();
        wb_en = 1'b0; tick();

        // SUB rd=1, rs=2
        in_valid = 1'b1; in_instr = 8'b0_01_01_10_0; #1;
        check_eq("sub_in_ready", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        check_eq("sub_out_valid", {7'd0, out_valid}, 8'h01);
        check_eq("sub_rs1", rs_data1, 8'h05);
        check_eq("sub_rs2", rs_data2, 8'h03);
        check_eq("sub_op",  {6'd0, alu_op}, 8'h01);
        check_eq("sub_src", {7'd0, alu_src}, 8'h00);
        check_eq("sub_rd",  {6'd0, rd_addr}, 8'h01);

        // I-type rd=3, imm=-4
        in_valid = 1'b1; in_instr = 8'b1_11_11100; #1;
        check_eq("imm_in_ready", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        check_eq("imm_out_valid", {7'd0, out_valid}, 8'h01);
        check_eq("imm_rs1", rs_data1, 8'h00);
        check_eq("imm_rs2", rs_data2, 8'hFC);
        check_eq("imm_op",  {6'd0, alu_op}, 8'h00);
        check_eq("imm_src", {7'd0, alu_src}, 8'h01);
        check_eq("imm_rd",  {6'd0, rd_addr}, 8'h03);

        // Retire pending R1 and R3
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h05; tick();
        wb_addr = 2'd3; wb_data = 8'h07; tick();
        wb_en = 1'b0;
        check_eq("drain_out_valid", {7'd0, out_valid}, 8'h00);

        // ADD rd=1, rs=2
        in_valid = 1'b1; in_instr = 8'b0_00_01_10_0; #1;
        check_eq("add_in_ready", {7'd0, in_ready}, 8'h01);
        tick();
        check_eq("add_rs1", rs_data1, 8'h05);
        check_eq("add_rs2", rs_data2, 8'h03);

        // Dependent I-type rd=1, imm=1
        in_instr = 8'b1_01_00001; #1;
        check_eq("dep_stall0", {7'd0, in_ready}, 8'h00);
        tick();
        check_eq("dep_stall1", {7'd0, in_ready}, 8'h00);
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h2A; #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        check_eq("dep_ready_wb_cycle", {7'd0, in_ready}, 8'h01);
        tick();
        wb_en = 1'b0;
`else
        check_eq("dep_ready_wb_cycle", {7'd0, in_ready}, 8'h00);
        tick();
        wb_en = 1'b0; #1;
        check_eq("dep_ready_after_wb", {7'd0, in_ready}, 8'h01);
        tick();
`endif
        in_valid = 1'b0;
        check_eq("dep_out_valid", {7'd0, out_valid}, 8'h01);
        check_eq("dep_rs1", rs_data1, 8'h2A);
        check_eq("dep_rs2", rs_data2, 8'h01);
        check_eq("dep_rd",  {6'd0, rd_addr}, 8'h01);

        // Backpressure: hold out_ready low for 3 cycles
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 8'b1_10_00101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_in_ready",  {7'd0, in_ready}, 8'h00);
            check_eq("bp_out_valid", {7'd0, out_valid}, 8'h01);
            check_eq("bp_rs1",       rs_data1, 8'h2A);
            check_eq("bp_rd",        {6'd0, rd_addr}, 8'h01);
            tick();
        end
        out_ready = 1'b1; #1;
        check_eq("b2b_in_ready0", {7'd0, in_ready}, 8'h01);
        tick();
        check_eq("b2b_valid0", {7'd0, out_valid}, 8'h01);
        check_eq("b2b_rs1_0",  rs_data1, 8'h03);
        check_eq("b2b_rs2_0",  rs_data2, 8'h05);
        check_eq("b2b_rd_0",   {6'd0, rd_addr}, 8'h02);
        in_instr = 8'b1_00_11111; #1;
        check_eq("b2b_in_ready1", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        check_eq("b2b_valid1", {7'd0, out_valid}, 8'h01);
        check_eq("b2b_rs2_1",  rs_data2, 8'hFF);
        check_eq("b2b_rd_1",   {6'd0, rd_addr}, 8'h00);

        // Reset with a held output and pending R0/R1/R2
        reset = 1'b1; tick();
        reset = 1'b0;
        check_eq("mid_rst_valid", {7'd0, out_valid}, 8'h00);
        check_eq("mid_rst_rs1",   rs_data1, 8'h00);
        check_eq("mid_rst_rs2",   rs_data2, 8'h00);
        in_valid = 1'b1; in_instr = 8'b0_01_01_10_0; #1;
        check_eq("mid_rst_pend_clr", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        check_eq("mid_rst_r1", rs_data1, 8'h00);
        check_eq("mid_rst_r2", rs_data2, 8'h00);
        check_eq("mid_rst_out_valid", {7'd0, out_valid}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
